vec_mac: RTL and testbench



---
 rtl/vec_mac_pkg.sv | 34 +++
 rtl/vec_mac_lanes.sv | 103 ++++++++++
 rtl/vec_mac.sv | 151 +++++++++++++++
 tb/tb_vec_mac.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_mac_pkg.sv
// vec_mac_pkg
// Shared definitions for the vector multiply-accumulate block and its bench.
//   DEF_*      : default parameter set (lanes, operand, accumulator, counter widths)
//   sat_max()  : largest signed value representable in acc_w bits
//   sat_min()  : smallest signed value representable in acc_w bits
//   lane_lsb() : bit offset of a lane inside a packed operand bus
package vec_mac_pkg;

  localparam int DEF_LANES  = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 24;
  localparam int DEF_CNT_W  = 16;

  // The saturation helpers work at a fixed wide width so they can be used
  // for any accumulator width; callers size-cast the result down.
  localparam int HELPER_W = 64;

  function automatic logic signed [HELPER_W-1:0] sat_max(input int acc_w);
    logic signed [HELPER_W-1:0] one;
    one = HELPER_W'(1);
    return (one <<< (acc_w - 1)) - one;
  endfunction

  function automatic logic signed [HELPER_W-1:0] sat_min(input int acc_w);
    logic signed [HELPER_W-1:0] one;
    one = HELPER_W'(1);
    return -(one <<< (acc_w - 1));
  endfunction

  function automatic int lane_lsb(input int lane, input int data_w);
    return lane * data_w;
  endfunction

endpackage

// File: rtl/vec_mac_lanes.sv
// vec_mac_lanes
// Two registered pipeline stages of the vector MAC:
//   S1: per-lane signed products (2*DATA_W each) plus valid/last.
//   S2: signed sum of all lane products (SUM_W wide) plus valid/last.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   en              : advance enable; when low every stage holds
//   in_valid/in_last: beat qualifier and end-of-vector flag
//   in_a, in_b      : packed signed operands, lane i at [i*DATA_W +: DATA_W]
//   s2_valid/s2_last: qualifiers of the S2 sum
//   s2_sum          : registered dot product of one beat
module vec_mac_lanes import vec_mac_pkg::*; #(
  parameter int LANES  = DEF_LANES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SUM_W  = 2 * DATA_W + $clog2(LANES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic                    in_last,
  input  logic [LANES*DATA_W-1:0] in_a,
  input  logic [LANES*DATA_W-1:0] in_b,
  output logic                    s2_valid,
  output logic                    s2_last,
  output logic [SUM_W-1:0]        s2_sum
);

  localparam int PROD_W = 2 * DATA_W;

  logic                          s1_valid_q, s1_valid_d;
  logic                          s1_last_q, s1_last_d;
  logic [LANES-1:0][PROD_W-1:0]  prod_q, prod_d;
  logic                          s2_valid_q, s2_valid_d;
  logic                          s2_last_q, s2_last_d;
  logic [SUM_W-1:0]              s2_sum_q, s2_sum_d;
  logic signed [SUM_W-1:0]       tree_sum;

  // S1 next state: operands are widened to the product width first so the
  // multiply is done in a full-precision signed context.
  always_comb begin
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;
    a_ext      = '0;
    b_ext      = '0;
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    prod_d     = prod_q;
    if (en) begin
      s1_valid_d = in_valid;
      s1_last_d  = in_last;
      for (int i = 0; i < LANES; i++) begin
        a_ext     = PROD_W'($signed(in_a[lane_lsb(i, DATA_W) +: DATA_W]));
        b_ext     = PROD_W'($signed(in_b[lane_lsb(i, DATA_W) +: DATA_W]));
        prod_d[i] = a_ext * b_ext;
      end
    end
  end

  // Sign-extended sum of all registered lane products.
  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      tree_sum = tree_sum + SUM_W'($signed(prod_q[i]));
    end
  end

  // S2 next state.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_last_d  = s2_last_q;
    s2_sum_d   = s2_sum_q;
    if (en) begin
      s2_valid_d = s1_valid_q;
      s2_last_d  = s1_last_q;
      s2_sum_d   = tree_sum;
    end
  end

  // Pipeline registers for S1 and S2.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      prod_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_sum_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      prod_q     <= prod_d;
      s2_valid_q <= s2_valid_d;
      s2_last_q  <= s2_last_d;
      s2_sum_q   <= s2_sum_d;
    end
  end

  assign s2_valid = s2_valid_q;
  assign s2_last  = s2_last_q;
  assign s2_sum   = s2_sum_q;

endmodule

// File: rtl/vec_mac.sv
// vec_mac
// Streams LANES-wide signed vectors in beats and emits one saturated dot
// product per vector, when the beat flagged last reaches the accumulator.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : input beat handshake (in_ready = !out_valid || out_ready)
//   in_a, in_b         : packed signed operands
//   in_last            : final beat of the current vector
//   out_valid/out_ready: result handshake
//   out_data           : saturated signed dot product
//   out_ovf            : saturation happened somewhere in this vector
//   out_beats          : beats in this vector, saturating
module vec_mac import vec_mac_pkg::*; #(
  parameter int LANES  = DEF_LANES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_a,
  input  logic [LANES*DATA_W-1:0] in_b,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_data,
  output logic                    out_ovf,
  output logic [CNT_W-1:0]        out_beats
);

  localparam int SUM_W = 2 * DATA_W + $clog2(LANES);
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W + 1)'(sat_max(ACC_W));
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W + 1)'(sat_min(ACC_W));
  localparam logic [CNT_W-1:0]      CNT_MAX = '1;

  logic             adv;
  logic             s2_valid, s2_last;
  logic [SUM_W-1:0] s2_sum;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sticky_q, sticky_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             out_ovf_q, out_ovf_d;
  logic [CNT_W-1:0] out_beats_q, out_beats_d;

  logic signed [ACC_W:0] acc_sum;
  logic [ACC_W-1:0]      acc_clamped;
  logic                  beat_ovf;
  logic [CNT_W-1:0]      cnt_inc;

  // The whole pipeline moves whenever the output register is free or being
  // drained this cycle.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  vec_mac_lanes #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .SUM_W  (SUM_W)
  ) u_lanes (
    .clk      (clk),
    .rst      (rst),
    .en       (adv),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_a     (in_a),
    .in_b     (in_b),
    .s2_valid (s2_valid),
    .s2_last  (s2_last),
    .s2_sum   (s2_sum)
  );

  // S3 arithmetic: the add is one bit wider than the accumulator so an
  // overflow is visible before clamping. ACC_W is at least one bit wider than
  // SUM_W, so this single extra bit is always enough.
  always_comb begin
    acc_sum     = {acc_q[ACC_W-1], acc_q}
                + {{(ACC_W + 1 - SUM_W){s2_sum[SUM_W-1]}}, s2_sum};
    acc_clamped = acc_sum[ACC_W-1:0];
    beat_ovf    = 1'b0;
    if (acc_sum > SAT_MAX) begin
      acc_clamped = SAT_MAX[ACC_W-1:0];
      beat_ovf    = 1'b1;
    end else if (acc_sum < SAT_MIN) begin
      acc_clamped = SAT_MIN[ACC_W-1:0];
      beat_ovf    = 1'b1;
    end
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Accumulator, counter and output register next state. A last beat loads
  // the output and clears the running state on the same edge, so the next
  // vector can start with no gap.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sticky_d    = sticky_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    out_beats_d = out_beats_q;
    if (adv) begin
      out_valid_d = 1'b0;
      if (s2_valid) begin
        if (s2_last) begin
          out_valid_d = 1'b1;
          out_data_d  = acc_clamped;
          out_ovf_d   = sticky_q | beat_ovf;
          out_beats_d = cnt_inc;
          acc_d       = '0;
          cnt_d       = '0;
          sticky_d    = 1'b0;
        end else begin
          acc_d    = acc_clamped;
          cnt_d    = cnt_inc;
          sticky_d = sticky_q | beat_ovf;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_beats_q <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_beats_q <= out_beats_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign out_beats = out_beats_q;

endmodule

// File: tb/tb_vec_mac.sv
// tb_vec_mac
// Scoreboard bench for vec_mac: the driver updates a plain-arithmetic
// reference model on every accepted beat and queues the expected result on
// each last beat; an independent monitor pops and compares on every output
// handshake.
module tb_vec_mac;
  import vec_mac_pkg::*;

  localparam int LANES  = DEF_LANES;
  localparam int DATA_W = DEF_DATA_W;
  localparam int ACC_W  = DEF_ACC_W;
  localparam int CNT_W  = DEF_CNT_W;

  localparam longint MAXV    = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint MINV    = -(longint'(1) <<< (ACC_W - 1));
  localparam longint CNT_MAX = (longint'(1) <<< CNT_W) - 1;

  typedef int lane_t[LANES];
  typedef struct {
    longint data;
    longint ovf;
    longint beats;
  } result_t;

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_a;
  logic [LANES*DATA_W-1:0] in_b;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [ACC_W-1:0]        out_data;
  logic                    out_ovf;
  logic [CNT_W-1:0]        out_beats;

  result_t expQ[$];
  result_t monExp;
  int      assertCount = 0;
  int      failCount   = 0;
  int      readyMode   = 0;
  longint  mAcc        = 0;
  longint  mOvf        = 0;
  longint  mCnt        = 0;
  lane_t   va, vb;

  vec_mac #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_beats (out_beats)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic lane_t fill(input int v);
    lane_t r;
    for (int i = 0; i < LANES; i++) r[i] = v;
    return r;
  endfunction

  // Reference model: exact dot product, clamped after every beat.
  task automatic modelBeat(input lane_t a, input lane_t b, input bit last);
    longint dot = 0;
    result_t r;
    for (int i = 0; i < LANES; i++) dot += longint'(a[i]) * longint'(b[i]);
    mAcc += dot;
    if (mAcc > MAXV) begin
      mAcc = MAXV;
      mOvf = 1;
    end else if (mAcc < MINV) begin
      mAcc = MINV;
      mOvf = 1;
    end
    if (mCnt < CNT_MAX) mCnt++;
    if (last) begin
      r.data  = mAcc;
      r.ovf   = mOvf;
      r.beats = mCnt;
      expQ.push_back(r);
      mAcc = 0;
      mOvf = 0;
      mCnt = 0;
    end
  endtask

  task automatic modelReset();
    mAcc = 0;
    mOvf = 0;
    mCnt = 0;
    expQ.delete();
  endtask

  // Present one beat just after a clock edge and hold it until accepted.
  task automatic applyStimulus(input lane_t a, input lane_t b, input bit last);
    bit accepted = 1'b0;
    int n = 0;
    in_valid = 1'b1;
    in_last  = last;
    for (int i = 0; i < LANES; i++) begin
      in_a[i*DATA_W +: DATA_W] = DATA_W'(a[i]);
      in_b[i*DATA_W +: DATA_W] = DATA_W'(b[i]);
    end
    while (!accepted && n < 1000) begin
      @(negedge clk);
      accepted = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (accepted) modelBeat(a, b, last);
    else checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (expQ.size() != 0) checkOutput("drain_timeout", expQ.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Downstream ready: 0 = always ready, 1 = stalled, 2 = random.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: a result transfers on the next edge whenever valid and ready
  // are both high mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_result", 1, 0);
        end else begin
          monExp = expQ.pop_front();
          checkOutput("out_data", longint'($signed(out_data)), monExp.data);
          checkOutput("out_ovf", longint'(out_ovf), monExp.ovf);
          checkOutput("out_beats", longint'(out_beats), monExp.beats);
        end
      end
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_a     = '0;
    in_b     = '0;

    // Reset state
    idle(3);
    checkOutput("reset_out_valid", longint'(out_valid), 0);
    checkOutput("reset_out_data", longint'(out_data), 0);
    checkOutput("reset_out_ovf", longint'(out_ovf), 0);
    checkOutput("reset_out_beats", longint'(out_beats), 0);
    rst = 1'b0;
    idle(1);
    checkOutput("in_ready_after_reset", longint'(in_ready), 1);

    // Single-beat vector and its latency
    va = '{1, 2, 3, 4};
    vb = '{5, 6, 7, 8};
    applyStimulus(va, vb, 1'b1);
    @(negedge clk);
    checkOutput("latency_edge1", longint'(out_valid), 0);
    @(negedge clk);
    checkOutput("latency_edge2", longint'(out_valid), 0);
    @(negedge clk);
    checkOutput("latency_edge3", longint'(out_valid), 1);
    waitDrain();

    // Back-to-back vectors: -4 over two beats, then 127
    va = fill(1); vb = fill(2);
    applyStimulus(va, vb, 1'b0);
    va = '{-3, 0, 0, 0}; vb = '{4, 0, 0, 0};
    applyStimulus(va, vb, 1'b1);
    va = '{127, 0, 0, 0}; vb = '{1, 0, 0, 0};
    applyStimulus(va, vb, 1'b1);
    waitDrain();

    // Positive saturation, then a clean vector
    va = fill(-128); vb = fill(-128);
    for (int k = 0; k < 128; k++) applyStimulus(va, vb, k == 127);
    va = '{1, 0, 0, 0}; vb = '{1, 0, 0, 0};
    applyStimulus(va, vb, 1'b1);
    waitDrain();

    // Negative saturation, then accumulation continues from the clamp
    va = fill(-128); vb = fill(127);
    for (int k = 0; k < 130; k++) applyStimulus(va, vb, 1'b0);
    va = fill(127); vb = fill(127);
    applyStimulus(va, vb, 1'b1);
    waitDrain();

    // Backpressure: three results queue behind a stalled output
    readyMode = 1;
    out_ready = 1'b0;
    va = '{1, 2, 3, 4}; vb = '{1, 2, 3, 4};
    for (int k = 0; k < 3; k++) applyStimulus(va, vb, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("stall_in_ready", longint'(in_ready), 0);
      checkOutput("stall_out_valid", longint'(out_valid), 1);
      checkOutput("stall_out_data", longint'($signed(out_data)), 30);
    end
    @(posedge clk);
    #1;
    readyMode = 0;
    out_ready = 1'b1;
    waitDrain();

    // Bubbles between beats
    va = fill(2); vb = fill(3);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(va, vb, k == 2);
      idle($urandom_range(0, 5));
    end
    waitDrain();

    // Reset in the middle of a vector
    va = fill(1); vb = fill(1);
    applyStimulus(va, vb, 1'b0);
    applyStimulus(va, vb, 1'b0);
    rst = 1'b1;
    modelReset();
    idle(1);
    checkOutput("midrst_out_valid", longint'(out_valid), 0);
    checkOutput("midrst_out_data", longint'(out_data), 0);
    checkOutput("midrst_out_ovf", longint'(out_ovf), 0);
    checkOutput("midrst_out_beats", longint'(out_beats), 0);
    rst = 1'b0;
    va = '{1, 0, 0, 0}; vb = '{9, 0, 0, 0};
    applyStimulus(va, vb, 1'b1);
    waitDrain();

    // Random vectors with random downstream backpressure and bubbles
    readyMode = 2;
    for (int v = 0; v < 25; v++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        for (int i = 0; i < LANES; i++) begin
          va[i] = int'($urandom_range(0, 255)) - 128;
          vb[i] = int'($urandom_range(0, 255)) - 128;
        end
        applyStimulus(va, vb, k == len - 1);
        idle($urandom_range(0, 2));
      end
    end
    waitDrain();
    readyMode = 0;
    idle(2);

    checkOutput("leftover_expected", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
